// File: rtl/coin_credit_acc_if.sv
// coin_credit_acc_if: payment-side bus between the coin/buy/selector sources,
// the dispenser FSM and the coin credit accumulator.
// The accumulator is the slave; whoever drives coins, buttons and Li is the master.
interface coin_credit_acc_if #(
  parameter int CW = 5
);
  logic          COIN1;
  logic          COIN5;
  logic          BUY;
  logic          CANCEL;
  logic [3:0]    SA;
  logic          Li;
  logic [2:0]    CIN;
  logic          E;
  logic          CHG;
  logic [CW-1:0] CREDIT;
  logic          BUSY;
  logic          ERR;

  modport master (
    output COIN1, COIN5, BUY, CANCEL, SA, Li,
    input  CIN, E, CHG, CREDIT, BUSY, ERR
  );

  modport slave (
    input  COIN1, COIN5, BUY, CANCEL, SA, Li,
    output CIN, E, CHG, CREDIT, BUSY, ERR
  );
endinterface

// File: rtl/coin_credit_acc.sv
// coin_credit_acc: payment front-end of the beverage dispenser.
// Accumulates coins into a saturating credit, sells the selection SA at
// price SA+PRICE_OFS, signals the dispenser (CIN/E), returns change and
// waits for the dispenser's Li before the next sale.
// Optional feature macro: CHANGE_RETURN_EN -- when defined the remainder of a
// sale is paid out on CHG; otherwise it stays in CREDIT as carry-over.
module coin_credit_acc #(
  parameter int CW         = 5,
  parameter int PRICE_OFS  = 2,
  parameter int LI_TIMEOUT = 63
) (
  input  logic             CLK1,
  input  logic             ResetManual,
  coin_credit_acc_if.slave bus
);

  localparam int AW = CW + 4;                   // headroom for credit + 6
  localparam int PW = CW + 1;                   // price width
  localparam int TW = $clog2(LI_TIMEOUT + 1);   // Li wait timer width
  localparam logic [AW-1:0] CMAX_W = AW'((1 << CW) - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SALE    = 2'd1,
    ST_CHANGE  = 2'd2,
    ST_WAIT_LI = 2'd3
  } state_t;

  state_t        state_q,     state_d;
  logic [CW-1:0] credit_q,    credit_d;
  logic [CW-1:0] refund_q,    refund_d;
  logic [CW-1:0] price_q,     price_d;
  logic          from_sale_q, from_sale_d;
  logic [TW-1:0] timer_q,     timer_d;
  logic          err_q,       err_d;
  logic [2:0]    cin_q,       cin_d;
  logic          e_q,         e_d;
  logic          chg_q,       chg_d;
  logic          busy_q,      busy_d;
  logic          armed_q,     armed_d;   // BUY has been seen low since the last sale

  logic          coin_s;
  logic [AW-1:0] add_s;
  logic [AW-1:0] sum_s;
  logic [CW-1:0] sat_s;
  logic [PW-1:0] price_s;
  logic [CW-1:0] remain_s;
  logic          buy_ok_s;

  // Coins are added before the buy comparison, so the sale sees post-add credit.
  assign coin_s   = bus.COIN1 | bus.COIN5;
  assign add_s    = (bus.COIN1 ? AW'(1) : AW'(0)) + (bus.COIN5 ? AW'(5) : AW'(0));
  assign sum_s    = AW'(credit_q) + add_s;
  assign sat_s    = (sum_s > CMAX_W) ? {CW{1'b1}} : sum_s[CW-1:0];
  assign price_s  = PW'(bus.SA) + PW'(PRICE_OFS);
  assign buy_ok_s = bus.BUY & armed_q & (bus.SA != 4'd0) & ({1'b0, sat_s} >= price_s);
  assign remain_s = credit_q - price_q;
  assign busy_d   = (state_d != ST_IDLE);

  // Next state plus next value of every registered output.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    refund_d    = refund_q;
    price_d     = price_q;
    from_sale_d = from_sale_q;
    timer_d     = timer_q;
    err_d       = err_q;
    cin_d       = cin_q;
    e_d         = 1'b0;
    chg_d       = 1'b0;
    armed_d     = armed_q | ~bus.BUY;
    case (state_q)
      ST_IDLE: begin
        credit_d = sat_s;
        if (coin_s) begin
          err_d = 1'b0;
        end else begin
          err_d = err_q;
        end
        if (bus.CANCEL) begin
          // CANCEL outranks BUY; an empty credit makes it a no-op.
          if (sat_s != {CW{1'b0}}) begin
            state_d     = ST_CHANGE;
            refund_d    = sat_s;
            from_sale_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (buy_ok_s) begin
          state_d = ST_SALE;
          e_d     = 1'b1;
          cin_d   = 3'b111;
          price_d = price_s[CW-1:0];   // price fits: it is <= credit
          armed_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SALE: begin
        credit_d    = remain_s;
`ifdef CHANGE_RETURN_EN
        refund_d    = remain_s;
`else
        refund_d    = {CW{1'b0}};
`endif
        from_sale_d = 1'b1;
        state_d     = ST_CHANGE;
      end
      ST_CHANGE: begin
        if (refund_q != {CW{1'b0}}) begin
          chg_d    = 1'b1;
          refund_d = refund_q - CW'(1);
          credit_d = credit_q - CW'(1);
        end else if (from_sale_q) begin
          state_d = ST_WAIT_LI;
          timer_d = {TW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_LI: begin
        credit_d = sat_s;
        if (coin_s) begin
          err_d = 1'b0;
        end else begin
          err_d = err_q;
        end
        if (bus.Li) begin
          cin_d   = 3'b000;
          state_d = ST_IDLE;
        end else if (timer_q == TW'(LI_TIMEOUT - 1)) begin
          // Timeout takes precedence over a coin clearing ERR in the same cycle.
          err_d   = 1'b1;
          cin_d   = 3'b000;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; ResetManual clears everything immediately.
  always_ff @(posedge CLK1 or posedge ResetManual) begin
    if (ResetManual) begin
      state_q     <= ST_IDLE;
      credit_q    <= {CW{1'b0}};
      refund_q    <= {CW{1'b0}};
      price_q     <= {CW{1'b0}};
      from_sale_q <= 1'b0;
      timer_q     <= {TW{1'b0}};
      err_q       <= 1'b0;
      cin_q       <= 3'b000;
      e_q         <= 1'b0;
      chg_q       <= 1'b0;
      busy_q      <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      refund_q    <= refund_d;
      price_q     <= price_d;
      from_sale_q <= from_sale_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      cin_q       <= cin_d;
      e_q         <= e_d;
      chg_q       <= chg_d;
      busy_q      <= busy_d;
      armed_q     <= armed_d;
    end
  end

  assign bus.CIN    = cin_q;
  assign bus.E      = e_q;
  assign bus.CHG    = chg_q;
  assign bus.CREDIT = credit_q;
  assign bus.BUSY   = busy_q;
  assign bus.ERR    = err_q;

endmodule

// File: tb/tb_coin_credit_acc.sv
// tb_coin_credit_acc: directed test-plan sequences followed by randomized
// traffic; a reference model predicts every cycle's outputs into a queue that
// a negedge monitor drains and compares against the DUT.
module tb_coin_credit_acc;
  localparam int CW         = 5;
  localparam int PRICE_OFS  = 2;
  localparam int LI_TIMEOUT = 63;
  localparam int CMAX       = (1 << CW) - 1;

  logic CLK1 = 1'b0;
  logic ResetManual = 1'b1;
  always #5 CLK1 = ~CLK1;

  coin_credit_acc_if #(.CW(CW)) bus ();

  coin_credit_acc #(.CW(CW), .PRICE_OFS(PRICE_OFS), .LI_TIMEOUT(LI_TIMEOUT)) dut (
    .CLK1        (CLK1),
    .ResetManual (ResetManual),
    .bus         (bus)
  );

  typedef struct packed {
    logic [2:0]    cin;
    logic          e;
    logic          chg;
    logic [CW-1:0] credit;
    logic          busy;
    logic          err;
  } snap_t;

  snap_t exp_q[$];
  snap_t mon_s;
  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the payment rules written with plain integers.
  typedef enum int {M_IDLE, M_SALE, M_CHANGE, M_WAIT} mode_t;
  mode_t m_mode;
  int m_credit, m_refund, m_price, m_waited;
  bit m_after_sale, m_paid, m_err, m_armed, m_e, m_chg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.cin    = m_paid ? 3'b111 : 3'b000;
    s.e      = m_e;
    s.chg    = m_chg;
    s.credit = CW'(m_credit);
    s.busy   = (m_mode != M_IDLE);
    s.err    = m_err;
    return s;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_credit = 0; m_refund = 0; m_price = 0; m_waited = 0;
    m_after_sale = 0; m_paid = 0; m_err = 0; m_armed = 1; m_e = 0; m_chg = 0;
  endtask

  task automatic model_step();
    int added  = (bus.COIN1 ? 1 : 0) + (bus.COIN5 ? 5 : 0);
    int topped = (m_credit + added > CMAX) ? CMAX : m_credit + added;
    int price  = int'(bus.SA) + PRICE_OFS;
    m_e = 0;
    m_chg = 0;
    case (m_mode)
      M_IDLE: begin
        m_credit = topped;
        if (added > 0) m_err = 0;
        if (bus.CANCEL) begin
          if (topped > 0) begin
            m_refund = topped; m_after_sale = 0; m_mode = M_CHANGE;
          end
        end else if (bus.BUY && m_armed && bus.SA != 4'd0 && topped >= price) begin
          m_mode = M_SALE; m_e = 1; m_paid = 1; m_price = price; m_armed = 0;
        end
      end
      M_SALE: begin
        m_credit = m_credit - m_price;
`ifdef CHANGE_RETURN_EN
        m_refund = m_credit;
`else
        m_refund = 0;
`endif
        m_after_sale = 1;
        m_mode = M_CHANGE;
      end
      M_CHANGE: begin
        if (m_refund > 0) begin
          m_chg = 1; m_refund--; m_credit--;
        end else if (m_after_sale) begin
          m_mode = M_WAIT; m_waited = 0;
        end else begin
          m_mode = M_IDLE;
        end
      end
      M_WAIT: begin
        m_credit = topped;
        if (added > 0) m_err = 0;
        if (bus.Li) begin
          m_paid = 0; m_mode = M_IDLE;
        end else begin
          m_waited++;
          if (m_waited == LI_TIMEOUT) begin
            m_err = 1; m_paid = 0; m_mode = M_IDLE;
          end
        end
      end
      default: m_mode = M_IDLE;
    endcase
    if (!bus.BUY) m_armed = 1;
  endtask

  // One clock of stimulus; the model's prediction is queued for the monitor.
  task automatic cyc(input bit c1, input bit c5, input bit buy, input bit cancel,
                     input logic [3:0] sa, input bit li);
    bus.COIN1 = c1; bus.COIN5 = c5; bus.BUY = buy; bus.CANCEL = cancel;
    bus.SA = sa; bus.Li = li;
    @(posedge CLK1);
    #1;
    model_step();
    exp_q.push_back(model_snap());
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_CIN"},    32'(bus.CIN),    32'd0);
    chk({tag, "_E"},      32'(bus.E),      32'd0);
    chk({tag, "_CHG"},    32'(bus.CHG),    32'd0);
    chk({tag, "_CREDIT"}, 32'(bus.CREDIT), 32'd0);
    chk({tag, "_BUSY"},   32'(bus.BUSY),   32'd0);
    chk({tag, "_ERR"},    32'(bus.ERR),    32'd0);
  endtask

  // Called right after cyc(): a 1-time-unit pulse between clock edges.
  task automatic pulse_reset();
    #1 ResetManual = 1'b1;
    #1 chk_zero("async_rst");
    ResetManual = 1'b0;
    model_reset();
    exp_q.delete();
    exp_q.push_back(model_snap());
  endtask

  // Monitor: on every falling edge compare the DUT with the oldest prediction.
  initial begin
    forever begin
      @(negedge CLK1);
      if (exp_q.size() > 0) begin
        mon_s = exp_q.pop_front();
        chk("CIN",    32'(bus.CIN),    32'(mon_s.cin));
        chk("E",      32'(bus.E),      32'(mon_s.e));
        chk("CHG",    32'(bus.CHG),    32'(mon_s.chg));
        chk("CREDIT", 32'(bus.CREDIT), 32'(mon_s.credit));
        chk("BUSY",   32'(bus.BUSY),   32'(mon_s.busy));
        chk("ERR",    32'(bus.ERR),    32'(mon_s.err));
      end
    end
  end

  int cnt;
  int rise_at;
  int li_pct;
  bit buy_lv;
  logic [3:0] sa_r;

  initial begin
    bus.COIN1 = 1'b0; bus.COIN5 = 1'b0; bus.BUY = 1'b0; bus.CANCEL = 1'b0;
    bus.SA = 4'd0; bus.Li = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK1);
    #2 chk_zero("init_rst");
    ResetManual = 1'b0;

    // Exact pay: price 3 with three COIN1.
    cyc(1, 0, 0, 0, 4'd1, 0);
    cyc(1, 0, 0, 0, 4'd1, 0);
    cyc(1, 0, 0, 0, 4'd1, 0);
    cyc(0, 0, 1, 0, 4'd1, 0);
    chk("exact_E", 32'(bus.E), 32'd1);
    chk("exact_CIN", 32'(bus.CIN), 32'd7);
    cnt = 0;
    repeat (3) begin cyc(0, 0, 0, 0, 4'd1, 0); cnt += int'(bus.CHG); end
    chk("exact_no_chg", 32'(cnt), 32'd0);
    chk("exact_credit", 32'(bus.CREDIT), 32'd0);
    cyc(0, 0, 0, 0, 4'd1, 1);
    chk("exact_li_cin", 32'(bus.CIN), 32'd0);
    chk("exact_li_busy", 32'(bus.BUSY), 32'd0);

    // Change: price 4 paid with COIN5.
    cyc(0, 1, 0, 0, 4'd2, 0);
    cyc(0, 0, 1, 0, 4'd2, 0);
    cnt = 0;
    repeat (5) begin cyc(0, 0, 0, 0, 4'd2, 0); cnt += int'(bus.CHG); end
`ifdef CHANGE_RETURN_EN
    chk("change_chg_count", 32'(cnt), 32'd1);
    chk("change_credit", 32'(bus.CREDIT), 32'd0);
`else
    chk("change_chg_count", 32'(cnt), 32'd0);
    chk("change_credit", 32'(bus.CREDIT), 32'd1);
`endif
    cyc(0, 0, 0, 0, 4'd2, 1);

    // Empty the credit, then insufficient credit and no selection.
    cyc(0, 0, 0, 1, 4'd0, 0);
    repeat (3) cyc(0, 0, 0, 0, 4'd0, 0);
    cyc(1, 0, 0, 0, 4'd1, 0);
    cyc(1, 0, 0, 0, 4'd1, 0);
    cyc(0, 0, 1, 0, 4'd1, 0);
    chk("insuff_E", 32'(bus.E), 32'd0);
    chk("insuff_credit", 32'(bus.CREDIT), 32'd2);
    chk("insuff_busy", 32'(bus.BUSY), 32'd0);
    cyc(1, 0, 0, 0, 4'd0, 0);
    cyc(1, 0, 0, 0, 4'd0, 0);
    cyc(1, 0, 0, 0, 4'd0, 0);
    cyc(0, 0, 1, 0, 4'd0, 0);
    chk("nosel_E", 32'(bus.E), 32'd0);
    chk("nosel_credit", 32'(bus.CREDIT), 32'd5);
    chk("nosel_busy", 32'(bus.BUSY), 32'd0);
    cyc(0, 0, 0, 0, 4'd0, 0);

    // Saturation, then CANCEL together with BUY.
    repeat (7) cyc(0, 1, 0, 0, 4'd1, 0);
    chk("sat_credit", 32'(bus.CREDIT), 32'd31);
    cyc(0, 0, 1, 1, 4'd1, 0);
    cnt = int'(bus.E);
    rise_at = 0;
    repeat (40) begin cyc(0, 0, 0, 0, 4'd1, 0); rise_at += int'(bus.CHG); cnt += int'(bus.E); end
    chk("cancel_chg_count", 32'(rise_at), 32'd31);
    chk("cancel_no_E", 32'(cnt), 32'd0);
    chk("cancel_credit", 32'(bus.CREDIT), 32'd0);

    // Timeout: sale then no Li.
    cyc(1, 0, 0, 0, 4'd1, 0);
    cyc(1, 0, 0, 0, 4'd1, 0);
    cyc(1, 0, 0, 0, 4'd1, 0);
    cyc(0, 0, 1, 0, 4'd1, 0);
    rise_at = 0;
    for (int i = 1; i <= 80; i++) begin
      cyc(0, 0, 0, 0, 4'd1, 0);
      if (bus.ERR && rise_at == 0) begin
        rise_at = i;
        chk("timeout_cin", 32'(bus.CIN), 32'd0);
        chk("timeout_busy", 32'(bus.BUSY), 32'd0);
      end
    end
    chk("timeout_cycle", 32'(rise_at), 32'd65);
    cyc(1, 0, 0, 0, 4'd1, 0);
    chk("err_clear", 32'(bus.ERR), 32'd0);

    // Asynchronous reset in the middle of a sale.
    cyc(0, 1, 0, 0, 4'd1, 0);
    cyc(0, 0, 1, 0, 4'd1, 0);
    cyc(0, 0, 0, 0, 4'd1, 0);
    chk("pre_rst_busy", 32'(bus.BUSY), 32'd1);
    pulse_reset();
    cyc(0, 0, 0, 0, 4'd1, 0);

    // Randomized traffic with varying dispenser responsiveness.
    buy_lv = 1'b0;
    sa_r = 4'd1;
    for (int seg = 0; seg < 9; seg++) begin
      li_pct = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 4 : 30);
      for (int k = 0; k < 300; k++) begin
        if ($urandom_range(0, 3) == 0) buy_lv = ~buy_lv;
        if ($urandom_range(0, 14) == 0) sa_r = 4'($urandom_range(0, 15));
        cyc($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, buy_lv,
            $urandom_range(0, 39) == 0, sa_r, $urandom_range(0, 99) < li_pct);
        if ($urandom_range(0, 599) == 0) pulse_reset();
      end
    end

    @(negedge CLK1);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
